// File: rtl/jtag_mem_loader.sv
// jtag_mem_loader: decodes the JTAG virtual-port word stream into input-memory
// writes. A packet is a header (command + payload count), a start address,
// N payload words and an XOR checksum over everything before it. Completion,
// checksum mismatch, bad command and inter-word timeout are reported to the
// controller as one-cycle pulses with a held cause code.
module jtag_mem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  CMD_WRITE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       in_data,
  input  logic              in_rdy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_SUM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // A zero TIMEOUT turns the watchdog off entirely.
  localparam bit          TO_EN   = (TIMEOUT > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  logic [1:0]        state;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       xor_acc;
  logic [31:0]       idle_cnt;
  logic              timeout_hit;
  logic              hdr_ok;
  logic              last_payload;
  logic              sum_ok;

  // Timeout fires on the TIMEOUT-th consecutive idle cycle inside a packet;
  // an arriving word in that same cycle takes priority.
  assign timeout_hit  = TO_EN && (state != S_IDLE) && !in_rdy && (idle_cnt == TO_LAST);
  assign hdr_ok       = (in_data[31:24] == CMD_WRITE);
  assign last_payload = ((words_loaded + 16'd1) == n_words);
  assign sum_ok       = (in_data == xor_acc);

  // Idle-cycle counter: only runs while a packet is open and no word arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= 32'd0;
    end else if ((state == S_IDLE) || in_rdy || timeout_hit) begin
      idle_cnt <= 32'd0;
    end else if (TO_EN) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Packet state machine and status reporting; busy tracks state != IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      err_code     <= ERR_NONE;
      n_words      <= 16'd0;
      words_loaded <= 16'd0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if (timeout_hit) begin
        // Partial packet is abandoned; payload already written stays.
        state    <= S_IDLE;
        busy     <= 1'b0;
        load_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (in_rdy) begin
        case (state)
          S_IDLE: begin
            if (hdr_ok) begin
              state        <= S_ADDR;
              busy         <= 1'b1;
              n_words      <= in_data[15:0];
              words_loaded <= 16'd0;
            end else begin
              load_err <= 1'b1;
              err_code <= ERR_CMD;
            end
          end
          S_ADDR: begin
            state <= (n_words == 16'd0) ? S_CHECK : S_DATA;
          end
          S_DATA: begin
            words_loaded <= words_loaded + 16'd1;
            if (last_payload) begin
              state <= S_CHECK;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (sum_ok) begin
              load_done <= 1'b1;
              err_code  <= ERR_NONE;
            end else begin
              load_err <= 1'b1;
              err_code <= ERR_SUM;
            end
          end
        endcase
      end
    end
  end

  // Running checksum and write pointer, updated by each accepted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xor_acc <= 32'd0;
      ptr     <= '0;
    end else if (in_rdy) begin
      case (state)
        S_IDLE: begin
          xor_acc <= in_data;
        end
        S_ADDR: begin
          xor_acc <= xor_acc ^ in_data;
          ptr     <= in_data[ADDR_W-1:0];
        end
        S_DATA: begin
          xor_acc <= xor_acc ^ in_data;
          ptr     <= ptr + ADDR_W'(1);
        end
        default: begin
          xor_acc <= xor_acc;
        end
      endcase
    end
  end

  // Memory write port: one registered write per accepted payload word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (in_rdy && (state == S_DATA)) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_jtag_mem_loader.sv
// Scoreboard bench for jtag_mem_loader: the driver builds packets, a
// packet-level model pushes expected writes/results, a monitor pops them.
module tb_jtag_mem_loader;
  localparam int AW = 10;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_rdy = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          load_done;
  logic          load_err;
  logic [1:0]    err_code;
  logic [15:0]   words_loaded;

  jtag_mem_loader #(.ADDR_W(AW), .TIMEOUT(TO), .CMD_WRITE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_rdy(in_rdy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .load_done(load_done), .load_err(load_err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { bit done; logic [1:0] code; logic [15:0] wl; int c; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int compared = 0;
  int mismatched = 0;
  int stamp = 0;
  logic [15:0] last_wl = 16'd0;
  logic [31:0] pay [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a write or a result.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got addr %h data %h, none expected", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr_data_busy", {mem_addr, mem_wdata, busy}, {w.a, w.d, 1'b1});
          chk("write_cycle", cyc, w.c);
        end
      end
      if (load_done || load_err) begin
        if (rq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got done %b err %b code %0d", load_done, load_err, err_code);
        end else begin
          res_t r;
          r = rq.pop_front();
          chk("result_done_err_code_wl_busy",
              {load_done, load_err, err_code, words_loaded, busy},
              {r.done, !r.done, r.code, r.wl, 1'b0});
          chk("result_cycle", cyc, r.c);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    in_rdy  = 1'b1;
    in_data = w;
    stamp   = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_rdy  = 1'b0;
      in_data = $urandom;
    end
  endtask

  task automatic push_res(input bit done, input logic [1:0] code, input logic [15:0] wl, input int c);
    res_t r;
    r.done = done; r.code = code; r.wl = wl; r.c = c;
    rq.push_back(r);
  endtask

  // Packet model: expected writes land at (start + i) mod 2^AW, the result
  // depends on the checksum or on an over-long gap after the address word.
  task automatic run_pkt(input logic [7:0] cmd, input logic [7:0] mid, input int n,
                         input logic [AW-1:0] a, input bit bad_sum,
                         input int gap_after_addr, input int max_gap);
    logic [31:0] acc;
    logic [31:0] w;
    wr_t         e;
    w = {cmd, mid, 16'(n)};
    send(w);
    if (cmd != 8'hA5) begin
      push_res(1'b0, 2'd1, last_wl, stamp + 1);
      return;
    end
    acc = w;
    last_wl = 16'd0;
    w = $urandom;
    w[AW-1:0] = a;
    send(w);
    acc ^= w;
    if (gap_after_addr >= TO) begin
      push_res(1'b0, 2'd3, 16'd0, stamp + 1 + TO);
      idle(gap_after_addr + 2);
      return;
    end
    idle(gap_after_addr);
    for (int i = 0; i < n; i++) begin
      send(pay[i]);
      e.a = AW'(int'(a) + i);
      e.d = pay[i];
      e.c = stamp + 1;
      wq.push_back(e);
      acc ^= pay[i];
      last_wl = 16'(i + 1);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
    send(acc ^ {31'd0, bad_sum});
    push_res(!bad_sum, bad_sum ? 2'd2 : 2'd0, 16'(n), stamp + 1);
  endtask

  initial begin
    logic [7:0] cmd;
    wr_t        e;
    #12;
    chk("reset_outputs", {mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code, words_loaded}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Wrapping 3-word packet, good then corrupted checksum.
    pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
    run_pkt(8'hA5, 8'h00, 3, 10'h3FE, 1'b0, 0, 0);
    run_pkt(8'hA5, 8'h00, 3, 10'h3FE, 1'b1, 0, 0);
    idle(2);

    // Bad command immediately followed by a valid packet.
    run_pkt(8'h5A, 8'h00, 1, 10'h000, 1'b0, 0, 0);
    pay[0] = 32'hDEAD_BEEF;
    run_pkt(8'hA5, 8'h12, 1, 10'h020, 1'b0, 0, 0);
    idle(1);

    // Empty payload.
    run_pkt(8'hA5, 8'h00, 0, 10'h010, 1'b0, 0, 0);
    idle(2);

    // Timeout after the address word, then a gap one short of it.
    run_pkt(8'hA5, 8'h00, 3, 10'h040, 1'b0, TO, 0);
    pay[0] = 32'hCAFE_0001;
    run_pkt(8'hA5, 8'h00, 1, 10'h050, 1'b0, TO - 1, 0);
    idle(2);

    // Reset after 2 of 4 payload words, then a fresh packet.
    for (int i = 0; i < 4; i++) pay[i] = $urandom;
    send(32'hA500_0004);
    send(32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      send(pay[i]);
      e.a = AW'(10'h200 + i); e.d = pay[i]; e.c = stamp + 1;
      wq.push_back(e);
    end
    idle(1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_packet", {mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code, words_loaded}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_wl = 16'd0;
    for (int i = 0; i < 4; i++) pay[i] = $urandom;
    run_pkt(8'hA5, 8'h00, 4, 10'h100, 1'b0, 0, 0);
    idle(1);

    // Randomized packets, some back-to-back.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 8; i++) pay[i] = $urandom;
      cmd = 8'hA5;
      if ($urandom_range(5, 0) == 0) begin
        cmd = 8'($urandom);
        if (cmd == 8'hA5) cmd = 8'h00;
      end
      run_pkt(cmd, 8'($urandom), $urandom_range(6, 0), AW'($urandom),
              ($urandom_range(3, 0) == 0), $urandom_range(3, 0), 2);
      idle($urandom_range(1, 0));
    end
    idle(3);

    for (int k = 0; k < 200 && (wq.size() + rq.size()) != 0; k++) @(negedge clk);
    chk("scoreboard_drained", wq.size() + rq.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
